// File: rtl/instr_mem_responder.sv
// Instruction memory responder: 8-bit fetch address in, 16-bit word out through a 2-entry response buffer.
// Latency: request accepted at edge N, word registered at N, pushed into buffer at N+1, visible after N+1.
// Backpressure: req_ready drops when pipe+buffer would exceed 2 words; LOAD entry drains pipe/buffer first.
// Optional build macro: INSTR_MEM_PARITY_EN adds per-word even parity and the par_inject input.
module instr_mem_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [15:0] NOP_WORD  = 16'h0000,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic        load_start,
  input  logic        load_done,
  input  logic        ld_valid,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
`ifdef INSTR_MEM_PARITY_EN
  input  logic        par_inject,
`endif
  output logic        loading
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t state, state_next;

  // Storage is a power-of-two array so the truncated address never needs a range check on the index itself.
  logic [15:0] mem_data [0:(1<<AW)-1];
`ifdef INSTR_MEM_PARITY_EN
  logic        mem_par  [0:(1<<AW)-1];
`endif

  logic        pipe_valid;
  logic [15:0] pipe_data;
  logic        pipe_err;

  logic [15:0] buf_data [0:1];
  logic        buf_err  [0:1];
  logic        head;
  logic [1:0]  count;

  logic        accept;
  logic        pop;
  logic        push;
  logic [2:0]  occupancy;
  logic [1:0]  count_next;
  logic        empty_after;
  logic        req_in_range;
  logic        ld_in_range;
  logic        ld_write;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] ld_idx;

  assign req_in_range = ({1'b0, req_addr} < DEPTH_W);
  assign ld_in_range  = ({1'b0, ld_addr} < DEPTH_W);
  assign req_idx      = req_addr[AW-1:0];
  assign ld_idx       = ld_addr[AW-1:0];

  assign rsp_valid  = (count != 2'd0);
  assign rsp_data   = buf_data[head];
  assign rsp_err    = buf_err[head];
  assign pop        = rsp_valid & rsp_ready;
  assign push       = pipe_valid;

  // Words committed after this edge: what is buffered plus the word in flight, less the one leaving.
  assign occupancy  = 3'(count) + 3'(pipe_valid) - 3'(pop);
  assign req_ready  = (state == S_RUN) && (occupancy < 3'd2);
  assign accept     = req_valid & req_ready;
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  // Nothing in flight and nothing buffered once this edge completes.
  assign empty_after = !accept && (count_next == 2'd0);

  // Writes land only in LOAD, including the cycle load_done arrives.
  assign ld_write = (state == S_LOAD) && ld_valid && ld_in_range;

  // Next-state and mode output; load_start outside RUN and load_done outside LOAD fall through to hold.
  always_comb begin
    state_next = state;
    loading    = 1'b0;
    case (state)
      S_RUN: begin
        if (load_start) state_next = empty_after ? S_LOAD : S_DRAIN;
      end
      S_DRAIN: begin
        loading = 1'b1;
        if (empty_after) state_next = S_LOAD;
      end
      S_LOAD: begin
        loading = 1'b1;
        if (load_done) state_next = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  // Mode register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // Program-load writes; memory is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (ld_write) begin
      mem_data[ld_idx] <= ld_data;
`ifdef INSTR_MEM_PARITY_EN
      mem_par[ld_idx]  <= (^ld_data) ^ par_inject;
`endif
    end
  end

  // Read stage: registers the fetched word (or the NOP for out-of-range addresses) on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_data  <= 16'h0000;
      pipe_err   <= 1'b0;
    end else begin
      pipe_valid <= accept;
      if (accept) begin
        if (req_in_range) begin
          pipe_data <= mem_data[req_idx];
`ifdef INSTR_MEM_PARITY_EN
          pipe_err  <= (^mem_data[req_idx]) != mem_par[req_idx];
`else
          pipe_err  <= 1'b0;
`endif
        end else begin
          pipe_data <= NOP_WORD;
          pipe_err  <= 1'b1;
        end
      end
    end
  end

  // Two-entry response FIFO; the pipe word always has a free slot because acceptance reserved it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data[0] <= 16'h0000;
      buf_data[1] <= 16'h0000;
      buf_err[0]  <= 1'b0;
      buf_err[1]  <= 1'b0;
      head        <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        buf_data[head ^ count[0]] <= pipe_data;
        buf_err[head ^ count[0]]  <= pipe_err;
      end
      if (pop) head <= ~head;
      count <= count_next;
    end
  end

endmodule
